// File: rtl/lynx_tape_pkg.sv
// Shared types and default timing constants for the Lynx tape capture block.
package lynx_tape_pkg;

    // Capture session state
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LEADER = 2'd1,
        ST_DATA   = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    // One-ce symbol produced by the period meter
    typedef enum logic [1:0] {
        SYM_NONE = 2'd0,
        SYM_ZERO = 2'd1,
        SYM_ONE  = 2'd2,
        SYM_GAP  = 2'd3
    } sym_t;

    // Default thresholds, in ce ticks
    localparam int DEF_CW         = 14;
    localparam int DEF_MIN_P      = 200;
    localparam int DEF_THRESH     = 2000;
    localparam int DEF_TIMEOUT    = 8000;
    localparam int DEF_LEADER_MIN = 64;

endpackage

// File: rtl/tape_period_meter.sv
// Synchronizes the tape bit, measures the time between rising edges and
// classifies each period into a symbol (zero, one, gap) valid for one ce.
module tape_period_meter
    import lynx_tape_pkg::*;
#(
    parameter int CW      = DEF_CW,
    parameter int MIN_P   = DEF_MIN_P,
    parameter int THRESH  = DEF_THRESH,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic clock,
    input  logic reset,
    input  logic ce,
    input  logic arm_clr,
    input  logic tape_in,
    output sym_t sym
);

    localparam logic [CW-1:0] MIN_C     = CW'(MIN_P);
    localparam logic [CW-1:0] THRESH_C  = CW'(THRESH);
    localparam logic [CW-1:0] TIMEOUT_C = CW'(TIMEOUT);
    localparam logic [CW-1:0] GAP_AT_C  = CW'(TIMEOUT - 1);

    logic          sync_1;
    logic          sync_2;
    logic          prev_ce;
    logic          armed;
    logic [CW-1:0] count;
    logic          rise;
    logic          restart;
    logic          set_arm;
    logic          gap;

    // Two-flop synchronizer, runs every clock regardless of ce
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_1 <= 1'b0;
            sync_2 <= 1'b0;
        end else begin
            sync_1 <= tape_in;
            sync_2 <= sync_1;
        end
    end

    assign rise = ce && sync_2 && !prev_ce;

    // Classify the edge against the running count; a glitch leaves the count running
    always_comb begin
        sym     = SYM_NONE;
        restart = 1'b0;
        set_arm = 1'b0;
        gap     = 1'b0;
        if (rise) begin
            if (!armed) begin
                set_arm = 1'b1;
                restart = 1'b1;
            end else if (count < MIN_C) begin
                restart = 1'b0;
            end else if (count <= THRESH_C) begin
                sym     = SYM_ZERO;
                restart = 1'b1;
            end else if (count < TIMEOUT_C) begin
                sym     = SYM_ONE;
                restart = 1'b1;
            end else begin
                set_arm = 1'b1;
                restart = 1'b1;
            end
        end
        if (ce && !restart && count == GAP_AT_C) begin
            sym = SYM_GAP;
            gap = 1'b1;
        end
    end

    // Saturating period counter, previous-ce sample and armed flag
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            prev_ce <= 1'b0;
            count   <= '0;
            armed   <= 1'b0;
        end else if (ce) begin
            prev_ce <= sync_2;
            if (restart)
                count <= '0;
            else if (count != TIMEOUT_C)
                count <= count + 1'b1;
            if (arm_clr || gap)
                armed <= 1'b0;
            else if (set_arm)
                armed <= 1'b1;
        end
    end

endmodule

// File: rtl/lynx_tape_capture.sv
// Decodes the Lynx cassette output waveform into bytes with a running address.
// Session flow: leader of zero-cycles, a sync one, then MSB-first data bytes,
// ended by a gap (clean end or mid-byte error) or by the motor dropping.
module lynx_tape_capture
    import lynx_tape_pkg::*;
#(
    parameter int CW         = DEF_CW,
    parameter int MIN_P      = DEF_MIN_P,
    parameter int THRESH     = DEF_THRESH,
    parameter int TIMEOUT    = DEF_TIMEOUT,
    parameter int LEADER_MIN = DEF_LEADER_MIN
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        ce,
    input  logic        motor,
    input  logic        tape_in,
    output logic [7:0]  byte_data,
    output logic        byte_valid,
    output logic [15:0] byte_addr,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam int            LW     = $clog2(LEADER_MIN + 1);
    localparam logic [LW-1:0] LMIN_C = LW'(LEADER_MIN);

    state_t        state;
    sym_t          sym;
    logic          arm_clr;
    logic [LW-1:0] leader_cnt;
    logic [2:0]    bitcnt;
    logic [7:0]    shreg;
    logic          bit_val;
    logic          is_bit;

    // A new session must see its first edge as an arming edge
    assign arm_clr = (state == ST_IDLE) && motor;
    assign is_bit  = (sym == SYM_ZERO) || (sym == SYM_ONE);
    assign bit_val = (sym == SYM_ONE);

    tape_period_meter #(
        .CW      (CW),
        .MIN_P   (MIN_P),
        .THRESH  (THRESH),
        .TIMEOUT (TIMEOUT)
    ) u_meter (
        .clock   (clock),
        .reset   (reset),
        .ce      (ce),
        .arm_clr (arm_clr),
        .tape_in (tape_in),
        .sym     (sym)
    );

    // Session state machine with shift register, byte strobe and address counter
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            leader_cnt <= '0;
            bitcnt     <= '0;
            shreg      <= '0;
            byte_data  <= '0;
            byte_valid <= 1'b0;
            byte_addr  <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            // Strobe lasts one clock; the address advances on the clock after it
            byte_valid <= 1'b0;
            if (byte_valid)
                byte_addr <= byte_addr + 16'd1;
            if (ce) begin
                case (state)
                    ST_IDLE: begin
                        if (motor) begin
                            state      <= ST_LEADER;
                            busy       <= 1'b1;
                            byte_addr  <= '0;
                            leader_cnt <= '0;
                            done       <= 1'b0;
                            err        <= 1'b0;
                        end
                    end
                    ST_LEADER: begin
                        if (!motor) begin
                            state <= ST_IDLE;
                            busy  <= 1'b0;
                        end else begin
                            case (sym)
                                SYM_ZERO: begin
                                    if (leader_cnt != LMIN_C)
                                        leader_cnt <= leader_cnt + 1'b1;
                                end
                                SYM_ONE: begin
                                    if (leader_cnt == LMIN_C) begin
                                        state  <= ST_DATA;
                                        bitcnt <= '0;
                                    end else begin
                                        leader_cnt <= '0;
                                    end
                                end
                                SYM_GAP:  leader_cnt <= '0;
                                default:  leader_cnt <= leader_cnt;
                            endcase
                        end
                    end
                    ST_DATA: begin
                        if (!motor) begin
                            state  <= ST_IDLE;
                            busy   <= 1'b0;
                            bitcnt <= '0;
                        end else if (is_bit) begin
                            shreg  <= {shreg[6:0], bit_val};
                            bitcnt <= bitcnt + 3'd1;
                            if (bitcnt == 3'd7) begin
                                byte_data  <= {shreg[6:0], bit_val};
                                byte_valid <= 1'b1;
                            end
                        end else if (sym == SYM_GAP) begin
                            state  <= ST_DONE;
                            busy   <= 1'b0;
                            done   <= 1'b1;
                            err    <= (bitcnt != 3'd0);
                            bitcnt <= '0;
                        end
                    end
                    ST_DONE: begin
                        if (!motor)
                            state <= ST_IDLE;
                    end
                    default: begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_lynx_tape_capture.sv
// Directed bench for lynx_tape_capture with small thresholds.
module tb_lynx_tape_capture;

    localparam int MIN_P      = 4;
    localparam int THRESH     = 20;
    localparam int TIMEOUT    = 80;
    localparam int LEADER_MIN = 8;
    localparam int P0         = 12;
    localparam int P1         = 40;

    logic        clock;
    logic        reset;
    logic        ce;
    logic        motor;
    logic        tape_in;
    logic [7:0]  byte_data;
    logic        byte_valid;
    logic [15:0] byte_addr;
    logic        busy;
    logic        done;
    logic        err;

    int checks;
    int errors;

    logic [23:0] exp_q[$];
    logic [23:0] got_q[$];

    typedef struct {
        string      name;
        int         lead_a;
        bit         fake_one;
        int         lead_b;
        int         n_bits;
        logic [7:0] data;
        bit         glitch;
        bit         exp_strobe;
        bit         exp_done;
        bit         exp_err;
        bit         exp_busy;
    } vec_t;

    vec_t vecs[6];

    lynx_tape_capture #(
        .CW         (14),
        .MIN_P      (MIN_P),
        .THRESH     (THRESH),
        .TIMEOUT    (TIMEOUT),
        .LEADER_MIN (LEADER_MIN)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .ce         (ce),
        .motor      (motor),
        .tape_in    (tape_in),
        .byte_data  (byte_data),
        .byte_valid (byte_valid),
        .byte_addr  (byte_addr),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    // clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // strobe monitor: record {addr, data} whenever byte_valid is seen
    always @(negedge clock) begin
        if (byte_valid)
            got_q.push_back({byte_addr, byte_data});
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_strobes(input string name);
        chk({name, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            chk({name, "_strobe"}, {8'h0, got_q[i]}, {8'h0, exp_q[i]});
        got_q.delete();
        exp_q.delete();
    endtask

    // one square-wave period; a glitch period carries a short low dip right after the rise
    task automatic send_period(input int p, input bit glitch);
        if (glitch) begin
            tape_in = 1'b1; wait_clk(1);
            tape_in = 1'b0; wait_clk(2);
            tape_in = 1'b1; wait_clk(3);
            tape_in = 1'b0; wait_clk(6);
        end else begin
            tape_in = 1'b1; wait_clk(p / 2);
            tape_in = 1'b0; wait_clk(p - p / 2);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--)
            send_period(b[i] ? P1 : P0, 1'b0);
    endtask

    task automatic start_session(input string name);
        motor   = 1'b0;
        tape_in = 1'b0;
        wait_clk(4);
        chk({name, "_idle_busy"}, 32'(busy), 32'd0);
        motor = 1'b1;
        wait_clk(2);
        chk({name, "_start_busy"}, 32'(busy), 32'd1);
        chk({name, "_start_addr"}, 32'(byte_addr), 32'd0);
        chk({name, "_start_done"}, 32'(done), 32'd0);
    endtask

    task automatic run_vec(input vec_t v);
        bit glitch_left;
        glitch_left = v.glitch;
        start_session(v.name);
        for (int i = 0; i < v.lead_a; i++) send_period(P0, 1'b0);
        if (v.fake_one) begin
            send_period(P1, 1'b0);
            for (int i = 0; i < v.lead_b; i++) send_period(P0, 1'b0);
        end
        send_period(P1, 1'b0);
        for (int i = 0; i < v.n_bits; i++) begin
            if (v.data[7 - i]) begin
                send_period(P1, 1'b0);
            end else begin
                send_period(P0, glitch_left);
                glitch_left = 1'b0;
            end
        end
        // closing rise, then hold the line high until the gap fires
        tape_in = 1'b1;
        wait_clk(TIMEOUT + 30);
        if (v.exp_strobe) exp_q.push_back({16'h0000, v.data});
        check_strobes(v.name);
        chk({v.name, "_done"}, 32'(done), 32'(v.exp_done));
        chk({v.name, "_err"}, 32'(err), 32'(v.exp_err));
        chk({v.name, "_busy"}, 32'(busy), 32'(v.exp_busy));
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        reset   = 1'b1;
        ce      = 1'b1;
        motor   = 1'b0;
        tape_in = 1'b0;

        vecs[0] = '{"single_a5",     10, 1'b0, 0, 8, 8'hA5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{"short_leader",   5, 1'b1, 8, 8, 8'h3C, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{"glitch_5a",     10, 1'b0, 0, 8, 8'h5A, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[3] = '{"midbyte_gap",   10, 1'b0, 0, 3, 8'hA5, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[4] = '{"leader_7",       7, 1'b0, 0, 8, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[5] = '{"leader_exact8",  8, 1'b0, 0, 8, 8'hC3, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

        // reset and idle
        wait_clk(3);
        chk("rst_data",  32'(byte_data),  32'd0);
        chk("rst_valid", 32'(byte_valid), 32'd0);
        chk("rst_addr",  32'(byte_addr),  32'd0);
        chk("rst_busy",  32'(busy),       32'd0);
        chk("rst_done",  32'(done),       32'd0);
        chk("rst_err",   32'(err),        32'd0);
        reset = 1'b0;
        wait_clk(2);
        for (int i = 0; i < 20; i++) send_period((i % 2 == 0) ? P0 : P1, 1'b0);
        check_strobes("idle_edges");
        chk("idle_busy", 32'(busy), 32'd0);

        // table-driven sessions
        for (int i = 0; i < 6; i++) run_vec(vecs[i]);

        // multi-byte session, then motor drop mid-byte
        start_session("multi");
        for (int i = 0; i < 10; i++) send_period(P0, 1'b0);
        send_period(P1, 1'b0);
        send_byte(8'h00);
        send_byte(8'hFF);
        send_byte(8'h81);
        send_period(P1, 1'b0);
        send_period(P0, 1'b0);
        send_period(P1, 1'b0);
        motor = 1'b0;
        wait_clk(3);
        exp_q.push_back({16'd0, 8'h00});
        exp_q.push_back({16'd1, 8'hFF});
        exp_q.push_back({16'd2, 8'h81});
        check_strobes("multi");
        chk("drop_busy", 32'(busy),      32'd0);
        chk("drop_done", 32'(done),      32'd0);
        chk("drop_err",  32'(err),       32'd0);
        chk("drop_addr", 32'(byte_addr), 32'd3);

        // restart clears the address
        motor = 1'b1;
        wait_clk(2);
        chk("restart_addr", 32'(byte_addr), 32'd0);
        chk("restart_busy", 32'(busy),      32'd1);

        // reset in the middle of a byte
        for (int i = 0; i < 10; i++) send_period(P0, 1'b0);
        send_period(P1, 1'b0);
        for (int i = 0; i < 4; i++) send_period(P1, 1'b0);
        reset = 1'b1;
        motor = 1'b0;
        wait_clk(2);
        chk("midrst_busy",  32'(busy),       32'd0);
        chk("midrst_valid", 32'(byte_valid), 32'd0);
        chk("midrst_addr",  32'(byte_addr),  32'd0);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) send_period(P1, 1'b0);
        wait_clk(10);
        check_strobes("midrst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
